// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard, redirect, instruction-ROM and IF/ID signals around the fetch stage
interface fetch_stage_if;
    logic        Stall;
    logic        FlushIFID;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] JumpAddress;
    logic [31:0] JumpRegister;
    logic [31:0] InstrMemData;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic [31:0] IFID_PC_4;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        AddrError;
    logic [31:0] FetchCount;
    modport master (
        output Stall, FlushIFID, PCSrc, BranchTarget, JumpAddress, JumpRegister, InstrMemData,
        input  PC, PC_4, IFID_PC_4, IFID_Instruction, IFID_Valid, AddrError, FetchCount
    );
    modport slave (
        input  Stall, FlushIFID, PCSrc, BranchTarget, JumpAddress, JumpRegister, InstrMemData,
        output PC, PC_4, IFID_PC_4, IFID_Instruction, IFID_Valid, AddrError, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.slave bus
);
    logic [31:0] pc_q, pc_d, ifid_pc_4_q, ifid_pc_4_d, ifid_instr_q, ifid_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d, pc_4, target;
    logic        ifid_valid_q, ifid_valid_d, addr_error_q, addr_error_d, redirect, load;
    always_comb begin
        pc_4 = pc_q + 32'd4;
        redirect = bus.PCSrc != 2'b00;
        target = bus.PCSrc == 2'b01 ? bus.BranchTarget :
                 bus.PCSrc == 2'b10 ? bus.JumpAddress : bus.JumpRegister;
        // a redirect must move the PC even while the hazard unit stalls
        pc_d = redirect ? {target[31:2], 2'b00} : bus.Stall ? pc_q : pc_4;
        addr_error_d = redirect && target[1:0] != 2'b00;
        load = !bus.FlushIFID && !bus.Stall;
        ifid_pc_4_d = bus.FlushIFID || !bus.Stall ? pc_4 : ifid_pc_4_q;
        ifid_instr_d = bus.FlushIFID ? NOP_WORD : bus.Stall ? ifid_instr_q : bus.InstrMemData;
        ifid_valid_d = bus.FlushIFID ? 1'b0 : bus.Stall ? ifid_valid_q : 1'b1;
        fetch_count_d = fetch_count_q + {31'd0, load};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            ifid_pc_4_q <= 32'd0;
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            ifid_pc_4_q <= ifid_pc_4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            addr_error_q <= addr_error_d;
            fetch_count_q <= fetch_count_d;
        end
    end
    assign bus.PC = pc_q;
    assign bus.PC_4 = pc_4;
    assign bus.IFID_PC_4 = ifid_pc_4_q;
    assign bus.IFID_Instruction = ifid_instr_q;
    assign bus.IFID_Valid = ifid_valid_q;
    assign bus.AddrError = addr_error_q;
    assign bus.FetchCount = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with directed plan steps and random traffic
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifid_pc_4;
        logic [31:0] ifid_instr;
        logic [31:0] cnt;
        logic        valid;
        logic        aerr;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    exp_t sb[$];
    exp_t m;
    exp_t mon_e;
    int n_chk = 0;
    int n_pass = 0;
    bit started = 0;
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0040_0000: rom = 32'h2008_0005;
            32'h0040_0004: rom = 32'h2009_0007;
            32'h0040_0008: rom = 32'h0109_5020;
            default:       rom = {a[15:0], ~a[15:0]};
        endcase
    endfunction
    always_comb bus.InstrMemData = rom(bus.PC);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("sb_pc", bus.PC, mon_e.pc);
            check("sb_ifid_pc_4", bus.IFID_PC_4, mon_e.ifid_pc_4);
            check("sb_ifid_instr", bus.IFID_Instruction, mon_e.ifid_instr);
            check("sb_valid", {31'd0, bus.IFID_Valid}, {31'd0, mon_e.valid});
            check("sb_aerr", {31'd0, bus.AddrError}, {31'd0, mon_e.aerr});
            check("sb_count", bus.FetchCount, mon_e.cnt);
        end
    end
    task automatic step(input logic rs, input logic st, input logic fl, input logic [1:0] src,
                        input logic [31:0] tgt);
        @(negedge clk);
        reset = rs;
        bus.Stall = st;
        bus.FlushIFID = fl;
        bus.PCSrc = src;
        bus.BranchTarget = src == 2'b01 ? tgt : $urandom;
        bus.JumpAddress = src == 2'b10 ? tgt : $urandom;
        bus.JumpRegister = src == 2'b11 ? tgt : $urandom;
        #1;
        if (started) check("pc_4_comb", bus.PC_4, m.pc + 32'd4);
        if (rs) begin
            m = '{pc: 32'h0040_0000, ifid_pc_4: 32'd0, ifid_instr: 32'd0, cnt: 32'd0, valid: 1'b0, aerr: 1'b0};
            started = 1;
        end else begin
            if (fl) begin
                m.ifid_instr = 32'd0;
                m.valid = 1'b0;
                m.ifid_pc_4 = m.pc + 32'd4;
            end else if (!st) begin
                m.ifid_instr = rom(m.pc);
                m.valid = 1'b1;
                m.ifid_pc_4 = m.pc + 32'd4;
                m.cnt = m.cnt + 32'd1;
            end
            m.aerr = src != 2'b00 && tgt[1:0] != 2'b00;
            if (src != 2'b00) m.pc = {tgt[31:2], 2'b00};
            else if (!st) m.pc = m.pc + 32'd4;
        end
        sb.push_back(m);
        @(posedge clk);
        #2;
    endtask
    initial begin
        bus.Stall = 0;
        bus.FlushIFID = 0;
        bus.PCSrc = 0;
        bus.BranchTarget = 0;
        bus.JumpAddress = 0;
        bus.JumpRegister = 0;
        step(1, 0, 0, 2'b00, 0);
        check("rst_pc", bus.PC, 32'h0040_0000);
        check("rst_instr", bus.IFID_Instruction, 32'h0);
        check("rst_valid", {31'd0, bus.IFID_Valid}, 32'd0);
        check("rst_count", bus.FetchCount, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 0);
        check("t1_pc", bus.PC, 32'h0040_000C);
        check("t1_ifid_pc_4", bus.IFID_PC_4, 32'h0040_000C);
        check("t1_instr", bus.IFID_Instruction, 32'h0109_5020);
        check("t1_count", bus.FetchCount, 32'd3);
        step(1, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        check("t2_stall_pc", bus.PC, 32'h0040_0008);
        check("t2_stall_instr", bus.IFID_Instruction, 32'h2009_0007);
        check("t2_stall_count", bus.FetchCount, 32'd2);
        step(0, 0, 0, 2'b00, 0);
        check("t2_resume_pc", bus.PC, 32'h0040_000C);
        check("t2_resume_instr", bus.IFID_Instruction, 32'h0109_5020);
        step(0, 0, 1, 2'b10, 32'h0040_0020);
        check("t3_pc", bus.PC, 32'h0040_0020);
        check("t3_instr", bus.IFID_Instruction, 32'h0);
        check("t3_valid", {31'd0, bus.IFID_Valid}, 32'd0);
        check("t3_count", bus.FetchCount, 32'd3);
        step(0, 0, 0, 2'b00, 0);
        check("t3_target_instr", bus.IFID_Instruction, 32'h0020_FFDF);
        check("t3_target_pc_4", bus.IFID_PC_4, 32'h0040_0024);
        step(0, 1, 0, 2'b11, 32'h0040_0013);
        check("t4_pc", bus.PC, 32'h0040_0010);
        check("t4_aerr", {31'd0, bus.AddrError}, 32'd1);
        check("t4_held_instr", bus.IFID_Instruction, 32'h0020_FFDF);
        step(0, 0, 0, 2'b00, 0);
        check("t4_aerr_pulse", {31'd0, bus.AddrError}, 32'd0);
        step(0, 0, 0, 2'b01, 32'hFFFF_FFFC);
        check("t5_pc", bus.PC, 32'hFFFF_FFFC);
        check("t5_pc_4_wrap", bus.PC_4, 32'h0);
        step(0, 0, 0, 2'b00, 0);
        check("t5_pc_wrap", bus.PC, 32'h0);
        check("t5_ifid_pc_4", bus.IFID_PC_4, 32'h0);
        check("t5_aerr", {31'd0, bus.AddrError}, 32'd0);
        step(1, 1, 0, 2'b01, 32'h1234_5678);
        check("t6_pc", bus.PC, 32'h0040_0000);
        check("t6_count", bus.FetchCount, 32'd0);
        check("t6_valid", {31'd0, bus.IFID_Valid}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b00, t);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core: PC register, next-PC selection, and the IF/ID pipeline register.
- Produces the registered PC_4 and instruction word consumed by the ID-stage jump-address decoder ({PC_4[31:28], Instr[25:0], 2'b0}) and the branch logic.
- Takes the resolved redirect targets back from ID/EX to steer the PC.
- The PC reset value follows the MARS text-segment base, so simulated PCs match MARS listings.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (MARS .text base).
- NOP_WORD, 32'h0000_0000, instruction injected into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- Stall  input  1  hazard unit: hold PC and IF/ID contents.
- FlushIFID  input  1  squash the instruction being captured into IF/ID.
- PCSrc  input  2  next-PC select: 00 PC+4, 01 BranchTarget, 10 JumpAddress, 11 JumpRegister.
- BranchTarget  input  32  taken-branch target from ID.
- JumpAddress  input  32  j/jal target from the ID jump-address decoder.
- JumpRegister  input  32  rs value for jr/jalr.
- InstrMemData  input  32  combinational instruction-ROM read data at address PC.
- PC  output  32  current fetch address (ROM address).
- PC_4  output  32  PC+4, combinational.
- IFID_PC_4  output  32  registered PC+4 of the instruction in ID.
- IFID_Instruction  output  32  registered instruction in ID.
- IFID_Valid  output  1  1 = IF/ID holds a real (non-squashed) instruction.
- AddrError  output  1  registered one-cycle pulse: a selected redirect target had bits [1:0] != 0.
- FetchCount  output  32  number of valid instructions accepted into IF/ID.

Behaviour:
- Reset, checked every edge with highest priority:
  - PC=RESET_PC, IFID_PC_4=0, IFID_Instruction=NOP_WORD, IFID_Valid=0, AddrError=0, FetchCount=0.
  - Reset asserted mid-operation discards all in-flight state on that edge.
- PC_4 = PC + 32'd4, modulo 2^32: PC=32'hFFFF_FFFC gives PC_4=0, with no flag.
- NextPC is selected by PCSrc. Redirect targets (PCSrc != 00) are forced to {target[31:2],2'b00}.
- AddrError is 1 in the cycle after a redirect with target[1:0] != 0 is taken; otherwise 0.
- PC update, per edge with no reset:
  - PCSrc != 00: PC <= NextPC, even if Stall=1. A redirect beats a stall.
  - PCSrc == 00 and Stall=1: PC holds.
  - Otherwise: PC <= PC_4.
- IF/ID update, per edge with no reset. Priority is FlushIFID > Stall > normal:
  - FlushIFID=1: IFID_Instruction <= NOP_WORD, IFID_Valid <= 0, IFID_PC_4 <= PC_4.
  - Stall=1 (no flush): all IF/ID registers hold.
  - Normal: IFID_PC_4 <= PC_4, IFID_Instruction <= InstrMemData, IFID_Valid <= 1.
- FetchCount increments by 1 on each edge where IF/ID loads with valid=1. It wraps at 2^32 and holds on stall or flush.
- Latency: an instruction at PC appears on IFID_* one edge later. A redirect issued in cycle n makes PC=target after edge n; the first target instruction is in ID after edge n+1.
- Stall+FlushIFID together: flush wins for IF/ID. PC follows the PC rules above.
- Fully synchronous. There are no combinational paths from Stall/Flush/PCSrc to PC or IFID_* outputs. Only PC_4 is combinational, and it depends on PC only.

Test Plan:
1. Reset, then 3 free-running cycles with ROM returning 32'h2008_0005, 32'h2009_0007, 32'h0109_5020 → PC 0x0040_0000→0x0040_0004→0x0040_0008→0x0040_000C. IFID_PC_4 lags one cycle. IFID_Valid=1 after the first edge; FetchCount=3.
2. Stall=1 for 2 cycles at PC=0x0040_0008 → PC, IFID_* and FetchCount all frozen. Release Stall → fetch resumes at 0x0040_0008, then 0x0040_000C.
3. PCSrc=10, JumpAddress=0x0040_0020, FlushIFID=1 → next PC=0x0040_0020, IFID_Instruction=0, IFID_Valid=0, FetchCount unchanged. The following cycle captures the word at 0x0040_0020.
4. PCSrc=11, JumpRegister=0x0040_0013, Stall=1 → PC=0x0040_0010 (redirect beats stall), AddrError=1 for exactly one cycle, IF/ID held.
5. Force PC to 0xFFFF_FFFC via PCSrc=01 → next edge PC=0x0000_0000, IFID_PC_4=0, no AddrError.
6. Assert reset mid-stream with PCSrc=01 and Stall=1 → all outputs return to reset values on that edge (PC=0x0040_0000, FetchCount=0).
